// File: rtl/dmi_abscmd_seq_if.sv
// Host-side request/response bundle and DMI master bundle used by dmi_abscmd_seq.
// In each interface, master is the requesting side and slave is the responding side.

interface dmi_abscmd_seq_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_regno;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [2:0]  resp_err;

    modport master (
        output req_valid, req_write, req_regno, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_write, req_regno, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface dmi_abscmd_seq_dmi_if;
    logic        dmi_valid;
    logic        dmi_ready;
    logic        dmi_write;
    logic [6:0]  dmi_addr;
    logic [31:0] dmi_wdata;
    logic [31:0] dmi_rdata;

    modport master (
        output dmi_valid, dmi_write, dmi_addr, dmi_wdata,
        input  dmi_ready, dmi_rdata
    );
    modport slave (
        input  dmi_valid, dmi_write, dmi_addr, dmi_wdata,
        output dmi_ready, dmi_rdata
    );
endinterface

// File: rtl/dmi_abscmd_seq.sv
// DMI master sequencer: one register access -> data0/command/abstractcs/data0/cmderr-clear sequence.
// Define DMI_ABSCMD_SEQ_TIMEOUT_EN to bound abstractcs polling to POLL_MAX reads (resp_err = 3'b111).

module dmi_abscmd_seq #(
    parameter int POLL_MAX   = 255,
    parameter int GAP_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    dmi_abscmd_seq_req_if.slave    req,
    dmi_abscmd_seq_dmi_if.master   dmi,
    output logic [2:0]             o_dbg_state
);

    localparam logic [6:0] ADDR_DATA0 = 7'h04;
    localparam logic [6:0] ADDR_ACS   = 7'h16;
    localparam logic [6:0] ADDR_CMD   = 7'h17;
    localparam int         GW         = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_DATA0 = 3'd1,
        WR_CMD   = 3'd2,
        POLL     = 3'd3,
        RD_DATA0 = 3'd4,
        CLR_ERR  = 3'd5,
        RESP     = 3'd6
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic           r_write;
    logic [15:0]    r_regno;
    logic [31:0]    r_wdata;
    logic [31:0]    r_rdata;
    logic [2:0]     r_err;
    logic [GW-1:0]  r_gap;

    logic           w_accept;
    logic           w_in_xfer;
    logic           w_dmi_valid;
    logic           w_xfer;
    logic           w_busy;
    logic [2:0]     w_cmderr;
    logic           w_timeout;
    logic           w_dmi_write;
    logic [6:0]     w_dmi_addr;
    logic [31:0]    w_dmi_wdata;
    logic [31:0]    w_cmd_word;

    assign w_accept    = req.req_valid && (r_state == IDLE);
    assign w_in_xfer   = (r_state == WR_DATA0) || (r_state == WR_CMD) || (r_state == POLL) ||
                         (r_state == RD_DATA0) || (r_state == CLR_ERR);
    // The gap counter only masks dmi_valid; the FSM already sits in the next transfer state.
    assign w_dmi_valid = w_in_xfer && (r_gap == '0);
    assign w_xfer      = w_dmi_valid && dmi.dmi_ready;
    assign w_busy      = dmi.dmi_rdata[12];
    assign w_cmderr    = dmi.dmi_rdata[10:8];
    assign w_cmd_word  = {8'h00, 1'b0, 3'd2, 2'b00, 1'b1, r_write, r_regno};

`ifdef DMI_ABSCMD_SEQ_TIMEOUT_EN
    localparam int CW = (POLL_MAX <= 255) ? 8 : $clog2(POLL_MAX + 1);
    logic [CW-1:0] r_poll_cnt;

    // Evaluated before the increment: true on the poll that brings the count to POLL_MAX.
    assign w_timeout = ((int'(r_poll_cnt) + 1) >= POLL_MAX);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_poll_cnt <= '0;
        end else if (r_state == RESP) begin
            r_poll_cnt <= '0;
        end else if (w_xfer && (r_state == POLL) && (r_poll_cnt != '1)) begin
            r_poll_cnt <= r_poll_cnt + CW'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next      = r_state;
        w_dmi_write = 1'b0;
        w_dmi_addr  = 7'h00;
        w_dmi_wdata = 32'h0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next = req.req_write ? WR_DATA0 : WR_CMD;
            end
            WR_DATA0: begin
                w_dmi_write = 1'b1;
                w_dmi_addr  = ADDR_DATA0;
                w_dmi_wdata = r_wdata;
                if (w_xfer) w_next = WR_CMD;
            end
            WR_CMD: begin
                w_dmi_write = 1'b1;
                w_dmi_addr  = ADDR_CMD;
                w_dmi_wdata = w_cmd_word;
                if (w_xfer) w_next = POLL;
            end
            POLL: begin
                w_dmi_addr = ADDR_ACS;
                if (w_xfer) begin
                    if (w_busy)                w_next = w_timeout ? RESP : POLL;
                    else if (w_cmderr != 3'd0) w_next = CLR_ERR;
                    else                       w_next = r_write ? RESP : RD_DATA0;
                end
            end
            RD_DATA0: begin
                w_dmi_addr = ADDR_DATA0;
                if (w_xfer) w_next = RESP;
            end
            CLR_ERR: begin
                w_dmi_write = 1'b1;
                w_dmi_addr  = ADDR_ACS;
                w_dmi_wdata = 32'h0000_0700;
                if (w_xfer) w_next = RESP;
            end
            RESP: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_write <= 1'b0;
            r_regno <= 16'h0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
            r_err   <= 3'd0;
            r_gap   <= '0;
        end else begin
            r_state <= w_next;
            if (w_xfer)            r_gap <= GW'(GAP_CYCLES);
            else if (r_gap != '0)  r_gap <= r_gap - GW'(1);
            if (w_accept) begin
                r_write <= req.req_write;
                r_regno <= req.req_regno;
                r_wdata <= req.req_wdata;
                r_err   <= 3'd0;
            end
            if (w_xfer && (r_state == POLL)) begin
                if (!w_busy && (w_cmderr != 3'd0)) r_err <= w_cmderr;
                else if (w_busy && w_timeout)      r_err <= 3'b111;
            end
            if (w_xfer && (r_state == RD_DATA0)) r_rdata <= dmi.dmi_rdata;
        end
    end

    assign req.req_ready  = (r_state == IDLE);
    assign req.resp_valid = (r_state == RESP);
    assign req.resp_rdata = r_rdata;
    assign req.resp_err   = r_err;
    assign dmi.dmi_valid  = w_dmi_valid;
    assign dmi.dmi_write  = w_dmi_write;
    assign dmi.dmi_addr   = w_dmi_addr;
    assign dmi.dmi_wdata  = w_dmi_wdata;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_dmi_abscmd_seq.sv
// Directed bench for dmi_abscmd_seq: vector table of register accesses against a scripted DM,
// plus hand sequences for long polling, timeout and mid-sequence reset.

module tb_dmi_abscmd_seq;

    localparam int GAP = 1;
`ifdef DMI_ABSCMD_SEQ_TIMEOUT_EN
    localparam int PMAX = 8;
`else
    localparam int PMAX = 255;
`endif

    typedef struct {
        bit          wr;
        logic [15:0] regno;
        logic [31:0] wdata;
        int          busy;
        logic [2:0]  cmderr;
        logic [31:0] dm_rdata;
        logic [31:0] cmd;
        logic [31:0] exp_rdata;
        logic [2:0]  exp_err;
        bit          stall;
        bit          spam;
    } vec_t;

    logic clk;
    logic resetn;
    logic [2:0] dbg_state;

    dmi_abscmd_seq_req_if req_if();
    dmi_abscmd_seq_dmi_if dmi_if();

    dmi_abscmd_seq #(.POLL_MAX(PMAX), .GAP_CYCLES(GAP)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req         (req_if),
        .dmi         (dmi_if),
        .o_dbg_state (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    // DM model configuration and observation
    int          cfg_busy;
    logic [2:0]  cfg_cmderr;
    logic [31:0] cfg_rdata;
    bit          cfg_stall;
    int          dm_polls;
    int          gap_viol;
    int          stab_viol;
    int          idle_cnt;
    bit          after_xfer;
    bit          held;
    bit          stalled;
    logic [39:0] held_val;
    logic [39:0] act_q[$];
    logic [39:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [39:0] cur;
        cur = {dmi_if.dmi_write, dmi_if.dmi_addr, dmi_if.dmi_wdata};
        if (!resetn) begin
            dmi_if.dmi_ready = 1'b0;
            dmi_if.dmi_rdata = 32'h0;
            after_xfer = 1'b0;
            held       = 1'b0;
            stalled    = 1'b0;
            idle_cnt   = GAP;
        end else if (dmi_if.dmi_valid) begin
            if (after_xfer && idle_cnt < GAP) gap_viol++;
            after_xfer = 1'b0;
            if (held && cur !== held_val) stab_viol++;
            if (cfg_stall && !stalled) begin
                dmi_if.dmi_ready = 1'b0;
                stalled  = 1'b1;
                held     = 1'b1;
                held_val = cur;
            end else begin
                dmi_if.dmi_ready = 1'b1;
                stalled = 1'b0;
                held    = 1'b0;
                act_q.push_back({cur[39:32], dmi_if.dmi_write ? cur[31:0] : 32'h0});
                if (!dmi_if.dmi_write && dmi_if.dmi_addr == 7'h16) begin
                    dmi_if.dmi_rdata = (dm_polls < cfg_busy) ? 32'h0000_1000 : {21'h0, cfg_cmderr, 8'h00};
                    dm_polls++;
                end else if (!dmi_if.dmi_write && dmi_if.dmi_addr == 7'h04) begin
                    dmi_if.dmi_rdata = cfg_rdata;
                end else begin
                    dmi_if.dmi_rdata = 32'h0;
                end
                after_xfer = 1'b1;
                idle_cnt   = 0;
            end
        end else begin
            dmi_if.dmi_ready = 1'b0;
            if (held) stab_viol++;
            held    = 1'b0;
            stalled = 1'b0;
            idle_cnt++;
        end
    end

    task automatic setup_dm(input vec_t v);
        cfg_busy   = v.busy;
        cfg_cmderr = v.cmderr;
        cfg_rdata  = v.dm_rdata;
        cfg_stall  = v.stall;
        dm_polls   = 0;
        gap_viol   = 0;
        stab_viol  = 0;
        act_q.delete();
    endtask

    task automatic issue_req(input vec_t v);
        int waited;
        waited = 0;
        while (!req_if.req_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("req_ready_idle", req_if.req_ready, 1'b1);
        req_if.req_valid = 1'b1;
        req_if.req_write = v.wr;
        req_if.req_regno = v.regno;
        req_if.req_wdata = v.wdata;
        @(negedge clk);
        req_if.req_valid = 1'b0;
        chk("req_ready_drop", req_if.req_ready, 1'b0);
    endtask

    task automatic run_vec(input string tag, input vec_t v, input int n_polls, input bit timeout);
        bit got;
        int n;
        setup_dm(v);
        exp_q.delete();
        if (v.wr) exp_q.push_back({1'b1, 7'h04, v.wdata});
        exp_q.push_back({1'b1, 7'h17, v.cmd});
        for (int i = 0; i < n_polls; i++) exp_q.push_back({1'b0, 7'h16, 32'h0});
        if (!timeout) begin
            if (v.cmderr != 3'd0) exp_q.push_back({1'b1, 7'h16, 32'h0000_0700});
            else if (!v.wr)       exp_q.push_back({1'b0, 7'h04, 32'h0});
        end

        issue_req(v);
        if (v.spam) begin
            for (int i = 0; i < 3; i++) begin
                req_if.req_valid = 1'b1;
                req_if.req_write = 1'b1;
                req_if.req_regno = 16'hFFFF;
                req_if.req_wdata = 32'h5555_AAAA;
                @(negedge clk);
            end
            req_if.req_valid = 1'b0;
        end

        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (req_if.resp_valid) got = 1'b1;
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL %s resp_wait: got no resp_valid expected one within 3000 cycles", tag);
            return;
        end
        chk({tag, " resp_rdata"}, req_if.resp_rdata, v.exp_rdata);
        chk({tag, " resp_err"}, req_if.resp_err, v.exp_err);
        @(negedge clk);
        chk({tag, " resp_pulse"}, req_if.resp_valid, 1'b0);
        chk({tag, " ready_back"}, req_if.req_ready, 1'b1);

        chk({tag, " dmi_count"}, act_q.size(), exp_q.size());
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s dmi_op%0d", tag, i), act_q[i], exp_q[i]);
        chk({tag, " gap"}, gap_viol, 0);
        chk({tag, " stable"}, stab_viol, 0);
    endtask

    vec_t tbl[7];
    vec_t v;

    initial begin
        resetn           = 1'b0;
        req_if.req_valid = 1'b0;
        req_if.req_write = 1'b0;
        req_if.req_regno = 16'h0;
        req_if.req_wdata = 32'h0;
        cfg_busy = 0; cfg_cmderr = 3'd0; cfg_rdata = 32'h0; cfg_stall = 1'b0;
        dm_polls = 0; gap_viol = 0; stab_viol = 0;

        //          wr    regno     wdata          busy cmderr dm_rdata       cmd            exp_rdata      err   stall spam
        tbl[0] = '{1'b0, 16'h1008, 32'h0000_0000, 0,   3'd0,  32'hDEAD_BEEF, 32'h0022_1008, 32'hDEAD_BEEF, 3'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 16'h07B1, 32'h8000_0100, 0,   3'd0,  32'h0000_0000, 32'h0023_07B1, 32'hDEAD_BEEF, 3'd0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 16'h1001, 32'h0000_0000, 5,   3'd0,  32'h1234_5678, 32'h0022_1001, 32'h1234_5678, 3'd0, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 16'h0300, 32'h0000_0000, 0,   3'd3,  32'hAAAA_5555, 32'h0022_0300, 32'h1234_5678, 3'd3, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 16'h1002, 32'h0000_0000, 1,   3'd2,  32'h0000_0000, 32'h0023_1002, 32'h1234_5678, 3'd2, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 16'h1002, 32'h0000_0000, 2,   3'd0,  32'h0000_0001, 32'h0022_1002, 32'h0000_0001, 3'd0, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 16'h07B0, 32'h0000_0000, 7,   3'd0,  32'hCAFE_F00D, 32'h0022_07B0, 32'hCAFE_F00D, 3'd0, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst req_ready", req_if.req_ready, 1'b1);
        chk("rst resp_valid", req_if.resp_valid, 1'b0);
        chk("rst resp_rdata", req_if.resp_rdata, 32'h0);
        chk("rst resp_err", req_if.resp_err, 3'd0);
        chk("rst dmi_valid", dmi_if.dmi_valid, 1'b0);
        chk("rst dmi_bus", {dmi_if.dmi_write, dmi_if.dmi_addr, dmi_if.dmi_wdata}, 40'h0);
        chk("rst state", dbg_state, 3'd0);
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            run_vec($sformatf("vec%0d", i), tbl[i], tbl[i].busy + 1, 1'b0);

`ifdef DMI_ABSCMD_SEQ_TIMEOUT_EN
        v = '{1'b1, 16'h1004, 32'h0000_0001, 1000, 3'd0, 32'h0, 32'h0023_1004, 32'hCAFE_F00D, 3'b111, 1'b0, 1'b0};
        run_vec("timeout", v, PMAX, 1'b1);
`else
        v = '{1'b0, 16'h1003, 32'h0000_0000, 10, 3'd0, 32'h0BAD_F00D, 32'h0022_1003, 32'h0BAD_F00D, 3'd0, 1'b0, 1'b0};
        run_vec("long_poll", v, 11, 1'b0);
`endif

        // Reset while a poll read is on the bus
        v = '{1'b0, 16'h1006, 32'h0, 1000, 3'd0, 32'h0, 32'h0022_1006, 32'h0, 3'd0, 1'b0, 1'b0};
        setup_dm(v);
        issue_req(v);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                if (dbg_state == 3'd3 && dmi_if.dmi_valid) seen = 1'b1;
                else @(negedge clk);
            end
            chk("rst_mid poll_seen", seen, 1'b1);
        end
        resetn = 1'b0;
        @(negedge clk);
        chk("rst_mid dmi_valid", dmi_if.dmi_valid, 1'b0);
        chk("rst_mid req_ready", req_if.req_ready, 1'b1);
        chk("rst_mid resp_valid", req_if.resp_valid, 1'b0);
        chk("rst_mid state", dbg_state, 3'd0);
        chk("rst_mid resp_rdata", req_if.resp_rdata, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        v = '{1'b0, 16'h1005, 32'h0, 0, 3'd0, 32'h5A5A_A5A5, 32'h0022_1005, 32'h5A5A_A5A5, 3'd0, 1'b0, 1'b0};
        run_vec("after_rst", v, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
